// File: rtl/glip_uart_host_control.sv
// glip_uart_host_control: host-side GLIP UART control layer; decodes device egress bytes into payload and
// send credit, encodes escaped payload, credit grants and reset commands gated by the credit held.
module glip_uart_host_control #(
  parameter int RX_CREDIT    = 512,
  parameter int CREDIT_WIDTH = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [7:0]              rx_data,
  input  logic                    rx_valid,
  output logic                    rx_ready,
  output logic [7:0]              tx_data,
  output logic                    tx_valid,
  input  logic                    tx_ready,
  input  logic [7:0]              app_in_data,
  input  logic                    app_in_valid,
  output logic                    app_in_ready,
  output logic [7:0]              app_out_data,
  output logic                    app_out_valid,
  input  logic                    app_out_ready,
  input  logic                    rst_req,
  input  logic                    rst_sel,
  input  logic                    rst_val,
  output logic                    rst_ack,
  output logic [CREDIT_WIDTH-1:0] send_credit,
  output logic                    error
);
  localparam int HALF = RX_CREDIT / 2;
  typedef enum logic [1:0] {R_IDLE, R_ESC, R_CRLO} rx_state_t;
  typedef enum logic [1:0] {T_IDLE, T_B1, T_B2, T_B3} tx_state_t;
  typedef enum logic [1:0] {K_PAY, K_CTL, K_RST, K_GNT} kind_t;
  rx_state_t rx_state_q, rx_state_d;
  tx_state_t tx_state_q, tx_state_d;
  kind_t kind_q, kind_d;
  logic [7:0] out_data_q, out_data_d, pay_q, pay_d, b2_q, b2_d, b3_q, b3_d;
  logic out_valid_q, out_valid_d, gpend_q, gpend_d, blk_q, blk_d, err_q, err_d;
  logic [6:0] hi_q, hi_d;
  logic [CREDIT_WIDTH-1:0] credit_q, credit_d;
  logic [13:0] cnt_q, cnt_d, gval_q, gval_d;
  logic rx_acc, tx_acc, out_hs, in_acc, emit, cr_add, esc_err, sat, gnt_add;
  logic [14:0] cr_val;
  logic [CREDIT_WIDTH:0] cr_sum;

  assign rx_ready      = !rst & (!out_valid_q | app_out_ready);
  assign rx_acc        = rx_valid & rx_ready;
  assign out_hs        = out_valid_q & app_out_ready;
  assign app_out_data  = out_data_q;
  assign app_out_valid = out_valid_q;
  assign tx_valid      = tx_state_q != T_IDLE;
  assign tx_acc        = tx_valid & tx_ready;
  assign tx_data       = tx_state_q == T_B1 ? (kind_q == K_PAY ? pay_q : 8'hFE) :
                         tx_state_q == T_B2 ? (kind_q == K_PAY ? 8'hFE : b2_q) :
                         tx_state_q == T_B3 ? b3_q : 8'h00;
  assign app_in_ready  = tx_state_q == T_IDLE & !rst_req & !gpend_q & credit_q != '0;
  assign in_acc        = app_in_valid & app_in_ready;
  assign rst_ack       = tx_acc & tx_state_q == T_B2 & kind_q == K_RST;
  assign send_credit   = credit_q;
  assign error         = err_q;

  always_comb begin
    rx_state_d = rx_state_q;
    hi_d       = hi_q;
    emit       = 1'b0;
    cr_add     = 1'b0;
    esc_err    = 1'b0;
    if (rx_acc)
      case (rx_state_q)
        R_IDLE: begin
          emit       = rx_data != 8'hFE;
          rx_state_d = emit ? R_IDLE : R_ESC;
        end
        R_ESC: begin
          emit       = rx_data == 8'hFE;
          hi_d       = rx_data[6:0];
          esc_err    = !emit & !rx_data[7];
          rx_state_d = (!emit & rx_data[7]) ? R_CRLO : R_IDLE;
        end
        default: begin
          cr_add     = 1'b1;
          rx_state_d = R_IDLE;
        end
      endcase
    out_valid_d = emit | (out_valid_q & !out_hs);
    out_data_d  = emit ? rx_data : out_data_q;
  end

  always_comb begin
    gnt_add    = out_hs & cnt_q == 14'(HALF - 1) & !blk_q;
    cnt_d      = out_hs ? (cnt_q == 14'(HALF - 1) ? 14'd0 : cnt_q + 14'd1) : cnt_q;
    cr_val     = {hi_q, rx_data};
    cr_sum     = {1'b0, credit_q} + (CREDIT_WIDTH + 1)'(cr_val);
    sat        = cr_add & (cr_val == '0 | cr_sum[CREDIT_WIDTH]);
    credit_d   = sat ? '1 : (cr_add ? cr_sum[CREDIT_WIDTH-1:0] : credit_q) - CREDIT_WIDTH'(in_acc);
    err_d      = err_q | esc_err | sat;
    tx_state_d = tx_state_q;
    kind_d     = kind_q;
    pay_d      = pay_q;
    b2_d       = b2_q;
    b3_d       = b3_q;
    gval_d     = gval_q + (gnt_add ? 14'(HALF) : 14'd0);
    gpend_d    = gpend_q | gnt_add;
    blk_d      = blk_q;
    case (tx_state_q)
      T_IDLE: begin
        tx_state_d = (rst_req | gpend_q | in_acc) ? T_B1 : T_IDLE;
        kind_d     = (rst_req | gpend_q) ? K_CTL : K_PAY;
        pay_d      = in_acc ? app_in_data : pay_q;
      end
      T_B1: if (tx_acc) begin
        tx_state_d = (kind_q == K_PAY & pay_q != 8'hFE) ? T_IDLE : T_B2;
        // leading FE is shared by both control messages, so the choice is made only once it is taken
        if (kind_q == K_CTL) begin
          kind_d = rst_req ? K_RST : K_GNT;
          b2_d   = rst_req ? {6'b0, rst_sel, rst_val} : {2'b10, gval_q[13:8]};
          b3_d   = gval_q[7:0];
          gval_d = rst_req ? gval_d : (gnt_add ? 14'(HALF) : 14'd0);
        end
      end
      T_B2: if (tx_acc) tx_state_d = kind_q == K_GNT ? T_B3 : T_IDLE;
      default: if (tx_acc) begin
        tx_state_d = T_IDLE;
        gpend_d    = gval_q != '0 | gnt_add;
      end
    endcase
    if (rst_ack & b2_q[1] & b2_q[0]) begin
      credit_d = '0;
      cnt_d    = '0;
      gpend_d  = 1'b0;
      gval_d   = '0;
      blk_d    = 1'b1;
    end
    if (rst_ack & b2_q[1] & !b2_q[0] & blk_q) begin
      blk_d   = 1'b0;
      gpend_d = 1'b1;
      gval_d  = 14'(RX_CREDIT);
    end
  end

  always_ff @(posedge clk)
    if (rst) begin
      rx_state_q  <= R_IDLE;
      tx_state_q  <= T_IDLE;
      kind_q      <= K_PAY;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      pay_q       <= '0;
      b2_q        <= '0;
      b3_q        <= '0;
      hi_q        <= '0;
      credit_q    <= '0;
      cnt_q       <= '0;
      gval_q      <= 14'(RX_CREDIT);
      gpend_q     <= 1'b1;
      blk_q       <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      rx_state_q  <= rx_state_d;
      tx_state_q  <= tx_state_d;
      kind_q      <= kind_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      pay_q       <= pay_d;
      b2_q        <= b2_d;
      b3_q        <= b3_d;
      hi_q        <= hi_d;
      credit_q    <= credit_d;
      cnt_q       <= cnt_d;
      gval_q      <= gval_d;
      gpend_q     <= gpend_d;
      blk_q       <= blk_d;
      err_q       <= err_d;
    end
endmodule

// File: tb/tb_glip_uart_host_control.sv
// tb_glip_uart_host_control: directed vectors for the host UART control layer
module tb_glip_uart_host_control;
  logic clk = 1'b0, rst = 1'b1;
  logic [7:0] rx_data = '0, tx_data, app_in_data = '0, app_out_data;
  logic rx_valid = 1'b0, rx_ready, tx_valid, tx_ready = 1'b1;
  logic app_in_valid = 1'b0, app_in_ready, app_out_valid, app_out_ready = 1'b1;
  logic rst_req = 1'b0, rst_sel = 1'b0, rst_val = 1'b0, rst_ack, error;
  logic [15:0] send_credit;
  int n_tests = 0, n_fail = 0, ack_cnt = 0, deliv = 0, viol = 0, a0;
  logic [7:0] tx_q[$], out_q[$];

  typedef struct {
    logic [23:0] bytes;
    int          n;
    int          nout;
    logic [7:0]  d;
    logic [15:0] cr;
  } rxv_t;
  rxv_t tbl[6];

  glip_uart_host_control #(.RX_CREDIT(512), .CREDIT_WIDTH(16)) dut (
    .clk(clk), .rst(rst),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .app_in_data(app_in_data), .app_in_valid(app_in_valid), .app_in_ready(app_in_ready),
    .app_out_data(app_out_data), .app_out_valid(app_out_valid), .app_out_ready(app_out_ready),
    .rst_req(rst_req), .rst_sel(rst_sel), .rst_val(rst_val), .rst_ack(rst_ack),
    .send_credit(send_credit), .error(error)
  );

  always #5 clk = ~clk;

  always @(negedge clk)
    if (!rst) begin
      if (tx_valid && tx_ready) tx_q.push_back(tx_data);
      if (app_out_valid && app_out_ready) out_q.push_back(app_out_data);
      if (rst_ack) ack_cnt++;
      if (app_out_valid && !app_out_ready && rx_ready) viol++;
    end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic rx_byte(input logic [7:0] b);
    int t;
    t = 0;
    rx_data = b;
    rx_valid = 1'b1;
    @(negedge clk);
    while (!rx_ready && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (t >= 100) chk("rx_timeout", 64'(t), 64'(0));
    @(posedge clk);
    #1 rx_valid = 1'b0;
  endtask

  task automatic app_send(input logic [7:0] b);
    int t;
    t = 0;
    app_in_data = b;
    app_in_valid = 1'b1;
    @(negedge clk);
    while (!app_in_ready && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (t >= 100) chk("app_in_timeout", 64'(t), 64'(0));
    @(posedge clk);
    #1 app_in_valid = 1'b0;
  endtask

  task automatic deliver(input int n);
    for (int i = 0; i < n; i++) rx_byte(8'h55);
    deliv += n;
    cyc(2);
  endtask

  task automatic wait_ack();
    int t;
    int a;
    t = 0;
    a = ack_cnt;
    while (ack_cnt == a && t < 100) begin
      @(posedge clk);
      #1 t++;
    end
    rst_req = 1'b0;
    if (t >= 100) chk("ack_timeout", 64'(t), 64'(0));
  endtask

  task automatic chk_tx(input string name, input int n, input logic [39:0] exp);
    logic [39:0] act;
    act = '0;
    foreach (tx_q[i]) act = {act[31:0], tx_q[i]};
    chk({name, "_len"}, 64'(tx_q.size()), 64'(n));
    chk(name, 64'(act), 64'(exp));
    tx_q.delete();
  endtask

  initial begin
    tbl[0] = '{24'hFE8003, 3, 0, 8'h00, 16'd3};
    tbl[1] = '{24'h100000, 1, 1, 8'h10, 16'd3};
    tbl[2] = '{24'hFEFE00, 2, 1, 8'hFE, 16'd3};
    tbl[3] = '{24'h7F0000, 1, 1, 8'h7F, 16'd3};
    tbl[4] = '{24'hFD0000, 1, 1, 8'hFD, 16'd3};
    tbl[5] = '{24'h000000, 1, 1, 8'h00, 16'd3};
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_rx_ready", 64'(rx_ready), 64'(0));
    chk("rst_tx_valid", 64'(tx_valid), 64'(0));
    chk("rst_app_in_ready", 64'(app_in_ready), 64'(0));
    chk("rst_app_out_valid", 64'(app_out_valid), 64'(0));
    chk("rst_credit", 64'(send_credit), 64'(0));
    chk("rst_error", 64'(error), 64'(0));
    chk("rst_ack", 64'(rst_ack), 64'(0));
    @(posedge clk);
    #1 rst = 1'b0;
    cyc(5);
    chk_tx("init_grant", 3, 40'hFE8200);
    chk("no_credit_ready", 64'(app_in_ready), 64'(0));
    for (int i = 0; i < 6; i++) begin
      out_q.delete();
      for (int j = 0; j < tbl[i].n; j++) rx_byte(tbl[i].bytes[23-8*j -: 8]);
      cyc(2);
      deliv += tbl[i].nout;
      chk($sformatf("vec%0d_nout", i), 64'(out_q.size()), 64'(tbl[i].nout));
      chk($sformatf("vec%0d_data", i), 64'(out_q.size() > 0 ? out_q[0] : 8'h00), 64'(tbl[i].d));
      chk($sformatf("vec%0d_credit", i), 64'(send_credit), 64'(tbl[i].cr));
    end
    app_send(8'h41);
    app_send(8'hFE);
    app_send(8'h42);
    cyc(6);
    chk_tx("payload", 4, 40'h41FEFE42);
    chk("credit_spent", 64'(send_credit), 64'(0));
    begin
      logic seen;
      seen = 1'b0;
      app_in_data = 8'h43;
      app_in_valid = 1'b1;
      repeat (8) begin
        @(negedge clk);
        seen |= app_in_ready;
      end
      @(posedge clk);
      #1 app_in_valid = 1'b0;
      chk("stall_no_credit", 64'(seen), 64'(0));
    end
    cyc(3);
    chk_tx("stall_tx", 0, 40'h0);
    out_q.delete();
    fork
      begin
        for (int i = 0; i < 40; i++) begin
          @(posedge clk);
          #1 app_out_ready = ~app_out_ready;
        end
      end
      begin
        rx_byte(8'h10);
        rx_byte(8'hFE);
        rx_byte(8'hFE);
        rx_byte(8'h20);
      end
    join
    app_out_ready = 1'b1;
    cyc(3);
    deliv += 3;
    chk("toggle_n", 64'(out_q.size()), 64'(3));
    chk("toggle_data", 64'(out_q.size() == 3 ? {out_q[0], out_q[1], out_q[2]} : 24'h0), 64'(24'h10FE20));
    chk("rx_ready_full", 64'(viol), 64'(0));
    deliver(256 - deliv);
    cyc(5);
    chk_tx("grant256", 3, 40'hFE8100);
    tx_ready = 1'b0;
    deliver(512);
    @(negedge clk);
    chk("held_valid", 64'(tx_valid), 64'(1));
    chk("held_data", 64'(tx_data), 64'(8'hFE));
    #6 tx_ready = 1'b1;
    cyc(8);
    chk_tx("grant512", 3, 40'hFE8200);
    tx_ready = 1'b0;
    rx_byte(8'hFE);
    rx_byte(8'h80);
    rx_byte(8'h05);
    cyc(2);
    chk("credit5", 64'(send_credit), 64'(5));
    deliver(256);
    app_in_data = 8'h99;
    app_in_valid = 1'b1;
    rst_sel = 1'b1;
    rst_val = 1'b1;
    rst_req = 1'b1;
    cyc(2);
    tx_ready = 1'b1;
    a0 = ack_cnt;
    wait_ack();
    cyc(10);
    chk("comm_rst_acks", 64'(ack_cnt - a0), 64'(1));
    chk_tx("comm_rst", 2, 40'hFE03);
    chk("comm_rst_credit", 64'(send_credit), 64'(0));
    chk("comm_rst_in_ready", 64'(app_in_ready), 64'(0));
    app_in_valid = 1'b0;
    rst_val = 1'b0;
    rst_req = 1'b1;
    wait_ack();
    cyc(10);
    chk_tx("rearm", 5, 40'hFE02FE8200);
    rx_byte(8'hFE);
    rx_byte(8'h80);
    rx_byte(8'h02);
    rst_sel = 1'b0;
    rst_val = 1'b1;
    rst_req = 1'b1;
    wait_ack();
    cyc(5);
    chk_tx("logic_rst", 2, 40'hFE01);
    chk("logic_rst_credit", 64'(send_credit), 64'(2));
    chk("no_error_yet", 64'(error), 64'(0));
    rx_byte(8'hFE);
    rx_byte(8'h05);
    cyc(2);
    chk("error_set", 64'(error), 64'(1));
    out_q.delete();
    rx_byte(8'h33);
    cyc(3);
    chk("error_sticky", 64'(error), 64'(1));
    chk("after_err_n", 64'(out_q.size()), 64'(1));
    chk("after_err_data", 64'(out_q.size() > 0 ? out_q[0] : 8'h00), 64'(8'h33));
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
